// File: rtl/rr_mux_arbiter4_pkg.sv
// rr_mux_arbiter4_pkg: shared state encoding, mux width and grant helper for the round-robin mux arbiter.
package rr_mux_arbiter4_pkg;

    localparam int MUX_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [MUX_W-1:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational circular-priority pick of the first set request starting at ptr.
module rr_pick4
    import rr_mux_arbiter4_pkg::*;
(
    input  logic [MUX_W-1:0] req,
    input  logic [1:0]       ptr,
    output logic             any,
    output logic [1:0]       idx
);

    always_comb begin
        any = |req;
        idx = ptr;
        // Descending scan so the offset closest to ptr is the one that sticks.
        for (int k = MUX_W - 1; k >= 0; k--)
            if (req[ptr + 2'(k)]) idx = ptr + 2'(k);
    end

endmodule

// File: rtl/rr_mux_arbiter4.sv
// rr_mux_arbiter4: round-robin arbiter with hold timeout driving a 4:1 mux select and enable.
module rr_mux_arbiter4
    import rr_mux_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MUX_W-1:0] req,
    input  logic             done,
    output logic [MUX_W-1:0] grant,
    output logic [1:0]       sel,
    output logic             en,
    output logic             timeout
);

    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);

    state_t            state;
    logic [1:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        pick_ptr;
    logic [1:0]        idx;
    logic              any;
    logic              hit;
    logic              rel;

    // A releasing owner re-picks from the slot after itself, putting itself last.
    assign pick_ptr = (state == ST_GRANT) ? sel + 2'd1 : ptr;
    assign hit      = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign rel      = done | ~req[sel] | hit;

    rr_pick4 u_pick (
        .req(req),
        .ptr(pick_ptr),
        .any(any),
        .idx(idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            grant    <= '0;
            sel      <= 2'd0;
            en       <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        state    <= ST_GRANT;
                        grant    <= onehot(idx);
                        sel      <= idx;
                        en       <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (rel) begin
                        ptr     <= sel + 2'd1;
                        timeout <= hit & ~done & req[sel];
                        if (any) begin
                            grant    <= onehot(idx);
                            sel      <= idx;
                            hold_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                            grant <= '0;
                            en    <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// tb_rr_mux_arbiter4: scoreboard bench for the round-robin mux arbiter and the mux it steers.
module tb_rr_mux_arbiter4;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic       e;
        logic       t;
    } exp_t;

    typedef struct packed {
        logic [3:0] r;
        logic       d;
        logic [3:0] g;
        logic [1:0] s;
        logic       e;
        logic       t;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       done;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       en;
    logic       timeout;
    logic [7:0] mux_in [4];
    logic [7:0] y;
    exp_t       q [$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter4 #(.MAX_HOLD(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .done(done),
        .grant(grant),
        .sel(sel),
        .en(en),
        .timeout(timeout)
    );

    // Downstream mux: Y = I[S] gated by E
    always_comb y = en ? mux_in[sel] : 8'h00;

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t x;
        #2;
        checks++;
        if ({grant, sel, en, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset_initial: got grant=%b sel=%0d en=%b timeout=%b, want all zero", grant, sel, en, timeout);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 4'b0100;
        q.push_back('{4'b0100, 2'd2, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        x = q.pop_front();
        checks++;
        if ({grant, sel, en, timeout} !== x) begin
            errors++;
            $display("FAIL reset_pregrant: got grant=%b sel=%0d en=%b timeout=%b, want %b %0d %b %b", grant, sel, en, timeout, x.g, x.s, x.e, x.t);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, sel, en, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset_midgrant: got grant=%b sel=%0d en=%b timeout=%b, want all zero", grant, sel, en, timeout);
        end
        do_reset();
    endtask

    task automatic test_single();
        stim_t st [3] = '{
            '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0},
            '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0},
            '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0}
        };
        exp_t x;
        foreach (st[i]) begin
            req = st[i].r;
            done = st[i].d;
            q.push_back('{st[i].g, st[i].s, st[i].e, st[i].t});
            @(posedge clk);
            #1;
            x = q.pop_front();
            checks++;
            if ({grant, sel, en, timeout} !== x) begin
                errors++;
                $display("FAIL single step %0d: got grant=%b sel=%0d en=%b timeout=%b, want %b %0d %b %b", i, grant, sel, en, timeout, x.g, x.s, x.e, x.t);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_round_robin();
        stim_t st [5] = '{
            '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0},
            '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0},
            '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0},
            '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0},
            '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0}
        };
        exp_t x;
        do_reset();
        foreach (st[i]) begin
            req = st[i].r;
            done = st[i].d;
            q.push_back('{st[i].g, st[i].s, st[i].e, st[i].t});
            @(posedge clk);
            #1;
            x = q.pop_front();
            checks++;
            if ({grant, sel, en, timeout} !== x) begin
                errors++;
                $display("FAIL round_robin step %0d: got grant=%b sel=%0d en=%b timeout=%b, want %b %0d %b %b", i, grant, sel, en, timeout, x.g, x.s, x.e, x.t);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_wrap();
        stim_t st [4] = '{
            '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0},
            '{4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0},
            '{4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0},
            '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0}
        };
        exp_t x;
        do_reset();
        foreach (st[i]) begin
            req = st[i].r;
            done = st[i].d;
            q.push_back('{st[i].g, st[i].s, st[i].e, st[i].t});
            @(posedge clk);
            #1;
            x = q.pop_front();
            checks++;
            if ({grant, sel, en, timeout} !== x) begin
                errors++;
                $display("FAIL wrap step %0d: got grant=%b sel=%0d en=%b timeout=%b, want %b %0d %b %b", i, grant, sel, en, timeout, x.g, x.s, x.e, x.t);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_timeout();
        exp_t x;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            done = 1'b0;
            req = (i < 9) ? 4'b1010 : (i < 17) ? 4'b1000 : 4'b0000;
            if (i < 8)
                q.push_back('{4'b0010, 2'd1, 1'b1, 1'b0});
            else if (i < 17)
                q.push_back('{4'b1000, 2'd3, 1'b1, (i == 8 || i == 16) ? 1'b1 : 1'b0});
            else
                q.push_back('{4'b0000, 2'd3, 1'b0, 1'b0});
            @(posedge clk);
            #1;
            x = q.pop_front();
            checks++;
            if ({grant, sel, en, timeout} !== x) begin
                errors++;
                $display("FAIL timeout cycle %0d: got grant=%b sel=%0d en=%b timeout=%b, want %b %0d %b %b", i, grant, sel, en, timeout, x.g, x.s, x.e, x.t);
            end
        end
    endtask

    task automatic test_drop_mux();
        stim_t st [4] = '{
            '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0},
            '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0},
            '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0},
            '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0}
        };
        exp_t x;
        logic [7:0] y_exp;
        do_reset();
        foreach (mux_in[i]) mux_in[i] = 8'(i * 8'h11 + 8'h0f) ^ 8'($urandom_range(0, 255) & 8'hf0);
        foreach (st[i]) begin
            req = st[i].r;
            done = st[i].d;
            q.push_back('{st[i].g, st[i].s, st[i].e, st[i].t});
            @(posedge clk);
            #1;
            x = q.pop_front();
            y_exp = x.e ? mux_in[x.s] : 8'h00;
            checks++;
            if ({grant, sel, en, timeout} !== x) begin
                errors++;
                $display("FAIL drop step %0d: got grant=%b sel=%0d en=%b timeout=%b, want %b %0d %b %b", i, grant, sel, en, timeout, x.g, x.s, x.e, x.t);
            end
            checks++;
            if (y !== y_exp) begin
                errors++;
                $display("FAIL mux_y step %0d: got %h, want %h", i, y, y_exp);
            end
        end
        done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        foreach (mux_in[i]) mux_in[i] = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_drop_mux();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
